// File: rtl/urcpu_mem_pkg.sv
// Shared memory-subsystem definitions: address/length widths and the
// sequencer FSM encoding, also used by the 20-bit address decoder.
package urcpu_mem_pkg;

    localparam int ADDR_WIDTH = 20;
    localparam int LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

endpackage : urcpu_mem_pkg

// File: rtl/addr_counter.sv
// Loadable word-address counter; increments modulo 2^WIDTH with no carry out.
module addr_counter #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule : addr_counter

// File: rtl/mem_addr_sequencer.sv
// Burst address sequencer feeding the 20-bit address decoder: accepts a
// start address and length, then steps one registered address per beat.
module mem_addr_sequencer
    import urcpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = urcpu_mem_pkg::ADDR_WIDTH,
    parameter int LEN_WIDTH  = urcpu_mem_pkg::LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  req_write,
    output logic [ADDR_WIDTH-1:0] addr_bits,
    output logic                  addr_valid,
    output logic                  addr_write,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done
);

    seq_state_t           state;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 accept;
    logic                 step;

    // req_ready is itself a register that is high only in IDLE.
    assign accept = req_ready && req_valid;
    assign step   = (state == ST_BURST) && mem_ready && (beat_cnt != '0);

    addr_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_addr_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (req_addr),
        .inc      (step),
        .count    (addr_bits)
    );

    // The status outputs are flops updated together with the state, so they
    // never depend combinationally on any input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            addr_write <= 1'b0;
            req_ready  <= 1'b1;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_BURST;
                        beat_cnt   <= req_len;
                        addr_write <= req_write;
                        req_ready  <= 1'b0;
                        addr_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (mem_ready) begin
                        if (beat_cnt != '0) begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end else begin
                            state      <= ST_DONE;
                            addr_valid <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    addr_valid <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule : mem_addr_sequencer

// File: tb/tb_mem_addr_sequencer.sv
// Directed bench for mem_addr_sequencer: vector table for the main flows plus
// hand-written reset and mid-burst async-reset sequences.
module tb_mem_addr_sequencer;

    localparam int AW = 20;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          req_write = 1'b0;
    logic [AW-1:0] addr_bits;
    logic          addr_valid;
    logic          addr_write;
    logic          mem_ready = 1'b0;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    mem_addr_sequencer #(
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_write  (req_write),
        .addr_bits  (addr_bits),
        .addr_valid (addr_valid),
        .addr_write (addr_write),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic          wr;
        logic          mr;
        logic          e_rdy;
        logic          e_val;
        logic [AW-1:0] e_addr;
        logic          e_wr;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_rdy, input logic e_val,
                                 input logic [AW-1:0] e_addr, input logic e_busy,
                                 input logic e_done);
        check({tag, ".req_ready"},  {31'd0, req_ready},  {31'd0, e_rdy});
        check({tag, ".addr_valid"}, {31'd0, addr_valid}, {31'd0, e_val});
        check({tag, ".addr_bits"},  {12'd0, addr_bits},  {12'd0, e_addr});
        check({tag, ".busy"},       {31'd0, busy},       {31'd0, e_busy});
        check({tag, ".done"},       {31'd0, done},       {31'd0, e_done});
    endtask

    function automatic vec_t mk(input logic vld, input logic [AW-1:0] addr,
                                input logic [LW-1:0] len, input logic wr, input logic mr,
                                input logic e_rdy, input logic e_val,
                                input logic [AW-1:0] e_addr, input logic e_wr,
                                input logic e_busy, input logic e_done);
        vec_t v;
        v.vld = vld; v.addr = addr; v.len = len; v.wr = wr; v.mr = mr;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_addr = e_addr; v.e_wr = e_wr;
        v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    initial begin
        // Each row: inputs held across one rising edge, outputs expected after it.
        // Single read at 0x00002.
        vecs[0]  = mk(1, 20'h00002, 0, 0, 1,   0, 1, 20'h00002, 0, 1, 0);
        vecs[1]  = mk(0, 20'h00000, 0, 0, 1,   0, 0, 20'h00002, 0, 1, 1);
        vecs[2]  = mk(0, 20'h00000, 0, 0, 1,   1, 0, 20'h00002, 0, 0, 0);
        // Four-beat write burst at 0x00010.
        vecs[3]  = mk(1, 20'h00010, 3, 1, 1,   0, 1, 20'h00010, 1, 1, 0);
        vecs[4]  = mk(0, 20'h00000, 0, 0, 1,   0, 1, 20'h00011, 1, 1, 0);
        vecs[5]  = mk(0, 20'h00000, 0, 0, 1,   0, 1, 20'h00012, 1, 1, 0);
        vecs[6]  = mk(0, 20'h00000, 0, 0, 1,   0, 1, 20'h00013, 1, 1, 0);
        vecs[7]  = mk(0, 20'h00000, 0, 0, 1,   0, 0, 20'h00013, 1, 1, 1);
        vecs[8]  = mk(0, 20'h00000, 0, 0, 1,   1, 0, 20'h00013, 1, 0, 0);
        // Wrap through the top of the address space.
        vecs[9]  = mk(1, 20'hFFFFE, 3, 0, 1,   0, 1, 20'hFFFFE, 0, 1, 0);
        vecs[10] = mk(0, 20'h00000, 0, 0, 1,   0, 1, 20'hFFFFF, 0, 1, 0);
        vecs[11] = mk(0, 20'h00000, 0, 0, 1,   0, 1, 20'h00000, 0, 1, 0);
        vecs[12] = mk(0, 20'h00000, 0, 0, 1,   0, 1, 20'h00001, 0, 1, 0);
        vecs[13] = mk(0, 20'h00000, 0, 0, 1,   0, 0, 20'h00001, 0, 1, 1);
        vecs[14] = mk(0, 20'h00000, 0, 0, 1,   1, 0, 20'h00001, 0, 0, 0);
        // Stalled burst at 0x00100 while a second request waits at 0x00555.
        vecs[15] = mk(1, 20'h00100, 2, 1, 0,   0, 1, 20'h00100, 1, 1, 0);
        vecs[16] = mk(1, 20'h00555, 0, 0, 1,   0, 1, 20'h00101, 1, 1, 0);
        vecs[17] = mk(1, 20'h00555, 0, 0, 0,   0, 1, 20'h00101, 1, 1, 0);
        vecs[18] = mk(1, 20'h00555, 0, 0, 0,   0, 1, 20'h00101, 1, 1, 0);
        vecs[19] = mk(1, 20'h00555, 0, 0, 1,   0, 1, 20'h00102, 1, 1, 0);
        vecs[20] = mk(1, 20'h00555, 0, 0, 1,   0, 0, 20'h00102, 1, 1, 1);
        vecs[21] = mk(1, 20'h00555, 0, 0, 1,   1, 0, 20'h00102, 1, 0, 0);
        // Held request accepted at the first IDLE edge, then a stalled single beat.
        vecs[22] = mk(1, 20'h00555, 0, 0, 0,   0, 1, 20'h00555, 0, 1, 0);
        vecs[23] = mk(0, 20'h00000, 0, 0, 0,   0, 1, 20'h00555, 0, 1, 0);
        vecs[24] = mk(0, 20'h00000, 0, 0, 1,   0, 0, 20'h00555, 0, 1, 1);
        vecs[25] = mk(0, 20'h00000, 0, 0, 0,   1, 0, 20'h00555, 0, 0, 0);

        // Reset must act without a clock edge.
        #1 rst = 1'b1;
        #1;
        check_outputs("reset", 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0);
        check("reset.addr_write", {31'd0, addr_write}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            req_valid = vecs[i].vld;
            req_addr  = vecs[i].addr;
            req_len   = vecs[i].len;
            req_write = vecs[i].wr;
            mem_ready = vecs[i].mr;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_val,
                          vecs[i].e_addr, vecs[i].e_busy, vecs[i].e_done);
            if (vecs[i].e_val)
                check($sformatf("vec%0d.addr_write", i), {31'd0, addr_write},
                      {31'd0, vecs[i].e_wr});
            @(negedge clk);
        end

        // Async reset during beat 2 of a 4-beat burst at 0x00020.
        req_valid = 1'b1; req_addr = 20'h00020; req_len = 8'd3; req_write = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check_outputs("ar_beat1", 1'b0, 1'b1, 20'h00020, 1'b1, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_outputs("ar_beat2", 1'b0, 1'b1, 20'h00021, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_outputs("ar_async", 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("ar_held", 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("ar_release", 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0);

        // New single read at 0x00005 after the aborted burst.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 20'h00005; req_len = 8'd0; req_write = 1'b0;
        @(posedge clk); #1;
        check_outputs("post_beat", 1'b0, 1'b1, 20'h00005, 1'b1, 1'b0);
        check("post_beat.addr_write", {31'd0, addr_write}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_outputs("post_done", 1'b0, 1'b0, 20'h00005, 1'b1, 1'b1);
        @(posedge clk); #1;
        check_outputs("post_idle", 1'b1, 1'b0, 20'h00005, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_addr_sequencer
